// File: rtl/toggle_meter.sv
// toggle_meter
// Measures the number of clk cycles between consecutive transitions of a slow
// square wave. Rising and falling transitions count alike. Each measurement
// is reported with a one-cycle strobe. Lock is declared after LOCK_COUNT
// consecutive in-tolerance measurements. A sticky flag marks a stalled input.
//
// Ports
//   clk           in   clock, rising edge
//   reset         in   asynchronous, active-high reset
//   enable        in   synchronous enable; low returns to IDLE and clears status
//   sig_in        in   monitored signal, asynchronous to clk
//   half_period   out  last measurement in clk cycles (held while idle/stalled)
//   period_valid  out  one-cycle strobe, half_period updated in the same cycle
//   locked        out  LOCK_COUNT consecutive matching measurements seen
//   timeout       out  sticky: no transition for TIMEOUT cycles
//
// state   | meaning
// --------+-------------------------------------------
// IDLE    | enable low, status cleared
// FIRST   | waiting for the reference edge
// MEASURE | counting cycles since the last edge
// STALL   | no edge within TIMEOUT cycles
module toggle_meter #(
    parameter int CNT_WIDTH  = 25,
    parameter int EXPECTED   = 10,
    parameter int TOLERANCE  = 0,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 sig_in,
    output logic [CNT_WIDTH-1:0] half_period,
    output logic                 period_valid,
    output logic                 locked,
    output logic                 timeout
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FIRST   = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;
    localparam logic [1:0] ST_STALL   = 2'd3;

    localparam int MW = $clog2(LOCK_COUNT + 1);

    // Tolerance window bounds held one bit wider so EXPECTED+TOLERANCE
    // cannot wrap.
    localparam logic [CNT_WIDTH:0]   WIN_LO   = (CNT_WIDTH+1)'(EXPECTED - TOLERANCE);
    localparam logic [CNT_WIDTH:0]   WIN_HI   = (CNT_WIDTH+1)'(EXPECTED + TOLERANCE);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);
    localparam logic [MW-1:0]        LOCK_MAX = MW'(LOCK_COUNT);

    logic                 s1, s2, s3;
    logic                 sig_edge;
    logic [1:0]           state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] meas;
    logic                 in_tol;
    logic [MW-1:0]        match_cnt;
    logic [MW-1:0]        match_next;

    // Synchronizer plus history flop; free-running so the history is
    // already valid when enable rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sig_edge = s2 ^ s3;

    // cnt never exceeds TIMEOUT-1, so the +1 cannot overflow.
    assign meas   = cnt + CNT_WIDTH'(1);
    assign in_tol = ({1'b0, meas} >= WIN_LO) && ({1'b0, meas} <= WIN_HI);

    always_comb begin
        match_next = '0;
        if (in_tol) begin
            match_next = (match_cnt == LOCK_MAX) ? match_cnt : match_cnt + MW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            match_cnt    <= '0;
            half_period  <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (!enable) begin
                state     <= ST_IDLE;
                cnt       <= '0;
                match_cnt <= '0;
                locked    <= 1'b0;
                timeout   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_FIRST;
                    end
                    ST_FIRST: begin
                        if (sig_edge) begin
                            state <= ST_MEASURE;
                            cnt   <= '0;
                        end
                    end
                    ST_MEASURE: begin
                        // An edge on the last count wins over the timeout.
                        if (sig_edge) begin
                            cnt          <= '0;
                            half_period  <= meas;
                            period_valid <= 1'b1;
                            match_cnt    <= match_next;
                            locked       <= (match_next == LOCK_MAX);
                        end else if (cnt == CNT_LAST) begin
                            state     <= ST_STALL;
                            timeout   <= 1'b1;
                            locked    <= 1'b0;
                            match_cnt <= '0;
                        end else begin
                            cnt <= cnt + CNT_WIDTH'(1);
                        end
                    end
                    ST_STALL: begin
                        // The recovering edge is only a new reference.
                        if (sig_edge) begin
                            state   <= ST_MEASURE;
                            cnt     <= '0;
                            timeout <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_toggle_meter.sv
module tb_toggle_meter;

    localparam int CW       = 25;
    localparam int EXP      = 10;
    localparam int LCNT     = 4;
    localparam int TMO      = 64;
    localparam int HLEN     = 32768;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          sig_in;
    logic [CW-1:0] hp [2];
    logic          pv [2];
    logic          lk [2];
    logic          to [2];

    int vectors     = 0;
    int miscompares = 0;
    int nstrobe     = 0;

    // Instance 0 uses the default tolerance, instance 1 allows +/-1.
    toggle_meter u_dut0 (
        .clk(clk), .reset(reset), .enable(enable), .sig_in(sig_in),
        .half_period(hp[0]), .period_valid(pv[0]), .locked(lk[0]), .timeout(to[0])
    );

    toggle_meter #(.TOLERANCE(1)) u_dut1 (
        .clk(clk), .reset(reset), .enable(enable), .sig_in(sig_in),
        .half_period(hp[1]), .period_valid(pv[1]), .locked(lk[1]), .timeout(to[1])
    );

    always #5 clk = ~clk;

    // Reference model: event/timestamp based. Edges are the sampled input
    // delayed by the two-stage synchronizer; intervals are timestamp
    // differences.
    bit hist [0:HLEN-1];
    int c;
    int m_mode [2];   // 0 idle, 1 waiting reference, 2 measuring, 3 stalled
    int m_last [2];
    int m_match[2];
    int m_half [2];
    bit m_pv   [2];
    bit m_lk   [2];
    bit m_to   [2];
    int m_tol  [2] = '{0, 1};
    bit e_now;

    function automatic bit smp(input int k);
        if (k < 0 || k >= HLEN) return 1'b0;
        return hist[k];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            c = 0;
            for (int i = 0; i < 2; i++) begin
                m_mode[i] = 0; m_last[i] = 0; m_match[i] = 0; m_half[i] = 0;
                m_pv[i] = 0; m_lk[i] = 0; m_to[i] = 0;
            end
        end else begin
            if (c < HLEN) hist[c] = sig_in;
            e_now = smp(c - 2) ^ smp(c - 3);
            for (int i = 0; i < 2; i++) begin
                m_pv[i] = 1'b0;
                if (!enable) begin
                    m_mode[i] = 0; m_match[i] = 0; m_lk[i] = 0; m_to[i] = 0;
                end else if (m_mode[i] == 0) begin
                    m_mode[i] = 1;
                end else if (m_mode[i] == 1) begin
                    if (e_now) begin m_mode[i] = 2; m_last[i] = c; end
                end else if (m_mode[i] == 2) begin
                    if (e_now) begin
                        int m, d;
                        m = c - m_last[i];
                        m_last[i] = c;
                        m_half[i] = m;
                        m_pv[i] = 1'b1;
                        d = (m > EXP) ? m - EXP : EXP - m;
                        if (d <= m_tol[i]) begin
                            if (m_match[i] < LCNT) m_match[i]++;
                        end else begin
                            m_match[i] = 0;
                        end
                        m_lk[i] = (m_match[i] == LCNT);
                    end else if (c - m_last[i] == TMO) begin
                        m_mode[i] = 3; m_to[i] = 1; m_lk[i] = 0; m_match[i] = 0;
                    end
                end else begin
                    if (e_now) begin m_mode[i] = 2; m_last[i] = c; m_to[i] = 0; end
                end
            end
            c++;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (hp[i] !== CW'(m_half[i]) || pv[i] !== m_pv[i] ||
                lk[i] !== m_lk[i] || to[i] !== m_to[i]) begin
                miscompares++;
                $display("FAIL model dut%0d t=%0t: got hp=%0d pv=%b lk=%b to=%b, want hp=%0d pv=%b lk=%b to=%b",
                         i, $time, hp[i], pv[i], lk[i], to[i], m_half[i], m_pv[i], m_lk[i], m_to[i]);
            end
        end
        if (pv[0] === 1'b1) nstrobe++;
    end

    task automatic check(input string name, input int actual, input int expect_v);
        vectors++;
        if (actual !== expect_v) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, actual, expect_v);
        end
    endtask

    task automatic iv(input int n);
        repeat (n) @(negedge clk);
        sig_in = ~sig_in;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; sig_in = 1'b0;
        repeat (10) begin @(negedge clk); sig_in = ~sig_in; end
        check("reset_pv", int'(pv[0]), 0);
        check("reset_hp", int'(hp[0]), 0);
        @(negedge clk); reset = 1'b0;
        wait_cyc(5);
        check("disabled_lk", int'(lk[0]), 0);
        check("disabled_pv", int'(pv[0]), 0);

        // Nominal: 8 edges 10 apart -> 7 strobes, locked.
        enable = 1'b1;
        wait_cyc(5);
        nstrobe = 0;
        repeat (8) iv(10);
        wait_cyc(4);
        check("nominal_strobes", nstrobe, 7);
        check("nominal_hp", int'(hp[0]), 10);
        check("nominal_lk", int'(lk[0]), 1);

        // Tolerance: 20 breaks lock, then 9,11,10,9 relocks dut1; 12 drops it.
        iv(6); iv(20); iv(9); iv(11); iv(10);
        wait_cyc(4);
        check("tol_lk_after3", int'(lk[1]), 0);
        iv(5);
        wait_cyc(4);
        check("tol_lk_after4", int'(lk[1]), 1);
        check("tol0_lk", int'(lk[0]), 0);
        iv(8);
        wait_cyc(4);
        check("tol_lk_12", int'(lk[1]), 0);
        check("tol_hp_12", int'(hp[1]), 12);

        // Timeout.
        iv(6); repeat (3) iv(10);
        wait_cyc(4);
        check("relock_lk", int'(lk[0]), 1);
        wait_cyc(66);
        check("stall_to", int'(to[0]), 1);
        check("stall_lk", int'(lk[0]), 0);
        iv(1);
        wait_cyc(4);
        check("stall_clear_to", int'(to[0]), 0);
        iv(60);
        wait_cyc(4);
        check("edge_at_timeout_hp", int'(hp[0]), 64);
        check("edge_at_timeout_to", int'(to[0]), 0);
        iv(6); repeat (3) iv(10);
        wait_cyc(4);
        check("stall_relock", int'(lk[0]), 1);

        // Enable drop and glitch.
        iv(6);
        wait_cyc(5);
        enable = 1'b0;
        wait_cyc(3);
        check("idle_lk", int'(lk[0]), 0);
        check("idle_hp_held", int'(hp[0]), 10);
        enable = 1'b1;
        wait_cyc(5);
        nstrobe = 0;
        iv(3);
        wait_cyc(4);
        check("reenable_ref_only", nstrobe, 0);
        iv(6);
        wait_cyc(4);
        check("reenable_hp", int'(hp[0]), 10);
        iv(6); iv(1);
        wait_cyc(4);
        check("glitch_hp", int'(hp[0]), 1);
        check("glitch_lk", int'(lk[0]), 0);

        // Randomized traffic checked by the model.
        for (int k = 0; k < 150; k++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r < 12)      iv(int'($urandom_range(8, 12)));
            else if (r < 15) iv(int'($urandom_range(1, 80)));
            else if (r < 17) begin
                enable = 1'b0;
                wait_cyc(int'($urandom_range(1, 5)));
                enable = 1'b1;
            end else         iv(1);
        end

        // Async reset mid-measurement while locked.
        repeat (6) iv(10);
        wait_cyc(4);
        check("pre_reset_lk", int'(lk[0]), 1);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("areset_hp", int'(hp[0]), 0);
        check("areset_pv", int'(pv[0]), 0);
        check("areset_lk", int'(lk[0]), 0);
        check("areset_to", int'(to[0]), 0);
        check("areset_lk1", int'(lk[1]), 0);
        sig_in = 1'b0;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(5);
        nstrobe = 0;
        repeat (5) iv(10);
        wait_cyc(4);
        check("post_reset_strobes", nstrobe, 4);
        check("post_reset_lk", int'(lk[0]), 1);
        check("post_reset_hp", int'(hp[0]), 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/toggle_meter.md
# toggle_meter

Receive-side companion to the team's clock-divider toggle generator. Monitors a slow square wave, typically a divided blink output or an external pin, and measures the number of `clk` cycles between consecutive transitions. It reports each measurement with a one-cycle valid strobe and declares lock after a run of in-tolerance measurements. It flags a stalled input when no transition arrives within a timeout window.

## Interface
- `CNT_WIDTH`, 25: width of the interval counter and of `half_period`.
- `EXPECTED`, 10: nominal cycles between transitions; must be < 2^CNT_WIDTH.
- `TOLERANCE`, 0: allowed absolute deviation from `EXPECTED`; must be < `EXPECTED`.
- `LOCK_COUNT`, 4: consecutive matching measurements required for lock; ≥ 1.
- `TIMEOUT`, 64: cycles without a transition before stall; must be > `EXPECTED` + `TOLERANCE` and < 2^CNT_WIDTH.
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  synchronous enable; low forces IDLE.
- `sig_in`  in  1  monitored signal, asynchronous to `clk`.
- `half_period`  out  CNT_WIDTH  last valid measurement in cycles.
- `period_valid`  out  1  one-cycle strobe; `half_period` updated in the same cycle.
- `locked`  out  1  `LOCK_COUNT` consecutive matching measurements seen.
- `timeout`  out  1  sticky stall flag.

## Operation
- Front end: a 2-flop synchronizer (`s1`, `s2`) feeds a history flop `s3`. `edge = s2 ^ s3`, so rising and falling transitions are treated alike. The synchronizer and history flops run regardless of `enable`, and all three reset to 0.
- States:
  - IDLE: `enable`=0.
  - FIRST: waiting for a reference edge.
  - MEASURE: counting the interval between edges.
  - STALL: timeout has fired.
- Transitions:
  - Any state with `enable`=0 → IDLE.
  - IDLE with `enable`=1 → FIRST.
  - FIRST on `edge` → MEASURE, `cnt`=0, no strobe.
  - MEASURE on `edge` → measurement, `cnt`=0, stay in MEASURE.
  - MEASURE with no `edge` and `cnt`==`TIMEOUT`-1 → STALL.
  - STALL on `edge` → MEASURE, `cnt`=0, no strobe, `timeout` cleared.
- Counter: in MEASURE with no edge, `cnt` increments by 1. It cannot exceed `TIMEOUT`-1 because STALL preempts it.
- Measurement on an edge in MEASURE: `half_period` ← `cnt`+1 and `period_valid` ← 1 for one cycle. Edges N cycles apart therefore report N.
- Match rule: `|m - EXPECTED| ≤ TOLERANCE`. Compute it without signed overflow, for example by comparing `m` against `EXPECTED-TOLERANCE` and `EXPECTED+TOLERANCE` held in CNT_WIDTH+1 bits.
- Match counter:
  - A match increments it, saturating at `LOCK_COUNT`.
  - A mismatch resets it to 0.
  - `locked` = (match count == `LOCK_COUNT`), registered.
- Entering STALL: `timeout` ← 1, `locked` ← 0, match count ← 0. `half_period` holds its value.
- Entering IDLE: `cnt`, match count, `locked`, `timeout` and `period_valid` all clear. `half_period` holds its last value.
- Edge coinciding with the timeout cycle (`cnt`==`TIMEOUT`-1): the edge wins. The measurement is `TIMEOUT`, which is a mismatch, and there is no STALL.
- Edge in the same cycle that `enable` falls: IDLE wins, with no strobe.
- A single-cycle glitch that survives synchronization produces two edges, so a measurement of 1 (mismatch) is reported.

## Timing
- Reset values: `half_period`=0, `period_valid`=0, `locked`=0, `timeout`=0, state IDLE, all internal flops 0.
- Reset is asserted asynchronously. Release is used synchronously, and the first state change can occur on the first `clk` edge after release.
- Latency: if `sig_in` changes before rising edge k, `period_valid` is high during the cycle after edge k+2. This latency is constant, so it does not bias measurements.
- `locked` rises in the same cycle as the `period_valid` of the `LOCK_COUNT`-th consecutive match. It falls in the same cycle as the strobe of a mismatch.
- `timeout` rises `TIMEOUT` cycles after the last edge was registered. It falls in the cycle after the next registered edge.
- `enable` low takes effect on the next edge: outputs are cleared one cycle later.

## Test plan
- Reset: hold `reset` with `sig_in` toggling → all outputs 0 throughout. Release with `enable`=0 → outputs stay 0.
- Nominal: defaults, `enable`=1, `sig_in` toggles every 10 cycles → no strobe on the first edge, then `period_valid` on every edge with `half_period`=10. `locked`=1 coincides with the 4th strobe.
- Tolerance: `TOLERANCE`=1, intervals 9,11,10,9 → `locked` after the 4th strobe. A next interval of 12 → strobe with 12 and `locked`=0 in the same cycle.
- Timeout: locked, then `sig_in` held → `timeout`=1 and `locked`=0 exactly 64 cycles after the last edge. An interval of exactly 64 instead → strobe with 64, no timeout. Resume toggling → no strobe on the first edge, `timeout` clears, re-lock after 4 more matches.
- Enable and glitch: drop `enable` mid-interval → IDLE, `locked`=0, `half_period` held. Re-enable → first edge is reference only. A 1-cycle `sig_in` pulse → strobe with `half_period`=1, mismatch.
- Async reset mid-measure: assert `reset` between clock edges while locked → outputs 0 immediately. After release and `enable`=1, behaviour matches the nominal case.
